// File: rtl/alu_pkg.sv
// Shared types and constants for the sequential ALU and its BCD corrector.
package alu_pkg;

    typedef enum logic [3:0] {
        ADD  = 4'd0,
        SUB  = 4'd1,
        CMP  = 4'd2,
        AND  = 4'd3,
        OR   = 4'd4,
        EOR  = 4'd5,
        ASL  = 4'd6,
        LSR  = 4'd7,
        ROL  = 4'd8,
        ROR  = 4'd9,
        INC  = 4'd10,
        DEC  = 4'd11,
        PASS = 4'd12
    } alu_op_t;

    typedef enum logic {
        IDLE   = 1'b0,
        ADJUST = 1'b1
    } alu_state_t;

    localparam logic [3:0] BCD_CORR = 4'd6;

endpackage

// File: rtl/bcd_adjust.sv
// Packed-BCD correction of a binary add/subtract intermediate.
// Each digit sees its binary nibble plus the binary nibble carry. The binary
// carry that entered the nibble is swapped for the decimal carry from the
// digit below, and the digit is then corrected by +6 (add) or -6 (subtract).
module bcd_adjust import alu_pkg::*; #(
    parameter int NDIGIT = 2
) (
    input  logic [4*NDIGIT-1:0] bin,
    input  logic [NDIGIT-1:0]   hc,
    input  logic                cin,
    input  logic                sub,
    output logic [4*NDIGIT-1:0] res,
    output logic                cout
);

    logic       hc_prev;
    logic       dc_prev;
    logic [5:0] dig_t;

    // Ripple the decimal carry from the least significant digit upward
    always_comb begin
        hc_prev = cin;
        dc_prev = cin;
        dig_t   = '0;
        res     = '0;
        for (int i = 0; i < NDIGIT; i++) begin
            dig_t = {1'b0, hc[i], bin[4*i +: 4]} - {5'd0, hc_prev} + {5'd0, dc_prev};
            if (sub) begin
                // Offset is +16 here, so a value of 16 or more means no borrow.
                dc_prev         = dig_t[5] | dig_t[4];
                res[4*i +: 4]   = dc_prev ? dig_t[3:0] : dig_t[3:0] - BCD_CORR;
            end else begin
                dc_prev         = (dig_t >= 6'd10);
                res[4*i +: 4]   = dc_prev ? dig_t[3:0] + BCD_CORR : dig_t[3:0];
            end
            hc_prev = hc[i];
        end
        cout = dc_prev;
    end

endmodule

// File: rtl/alu_seq.sv
// Registered 6502-style ALU with valid/ready handshakes on input and output.
// Binary ops complete in one cycle. Decimal ADD/SUB adds one ADJUST cycle.
module alu_seq import alu_pkg::*; #(
    parameter int WIDTH      = 8,
    parameter bit DECIMAL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             carry_in,
    input  logic             decimal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             sign
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    alu_state_t       state, state_nx;
    alu_op_t          op_p0;
    logic             accept, dec_start, is_sub, cin_eff;
    logic [WIDTH-1:0] b_eff;
    logic [WIDTH:0]   sum_p0;
    logic [WIDTH-1:0] v_vec_p0;
    logic [WIDTH-1:0] res_p0;
    logic             c_p0, v_p0;
    logic [WIDTH-1:0] adj_res;
    logic             adj_c, adj_v;

    assign op_p0     = alu_op_t'(op);
    assign in_ready  = (state == IDLE) && (!out_valid || out_ready);
    assign accept    = in_valid && in_ready;
    assign is_sub    = (op_p0 == SUB) || (op_p0 == CMP);
    assign dec_start = DECIMAL_EN && decimal && ((op_p0 == ADD) || (op_p0 == SUB));
    assign b_eff     = is_sub ? ~b : b;
    assign cin_eff   = (op_p0 == CMP) ? 1'b1 : carry_in;
    assign sum_p0    = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin_eff};
    // With b_eff = ~b this reduces to the subtract overflow rule.
    assign v_vec_p0  = ~(a ^ b_eff) & (a ^ sum_p0[WIDTH-1:0]);

    // Stage p0: binary result and flag candidates; C/V default to the held flags
    always_comb begin
        res_p0 = a;
        c_p0   = carry_out;
        v_p0   = overflow;
        case (op_p0)
            ADD, SUB: begin
                res_p0 = sum_p0[WIDTH-1:0];
                c_p0   = sum_p0[WIDTH];
                v_p0   = v_vec_p0[WIDTH-1];
            end
            CMP: begin
                res_p0 = sum_p0[WIDTH-1:0];
                c_p0   = sum_p0[WIDTH];
            end
            AND: res_p0 = a & b;
            OR:  res_p0 = a | b;
            EOR: res_p0 = a ^ b;
            ASL: begin
                res_p0 = {a[WIDTH-2:0], 1'b0};
                c_p0   = a[WIDTH-1];
            end
            LSR: begin
                res_p0 = {1'b0, a[WIDTH-1:1]};
                c_p0   = a[0];
            end
            ROL: begin
                res_p0 = {a[WIDTH-2:0], carry_in};
                c_p0   = a[WIDTH-1];
            end
            ROR: begin
                res_p0 = {carry_in, a[WIDTH-1:1]};
                c_p0   = a[0];
            end
            INC:     res_p0 = a + ONE;
            DEC:     res_p0 = a - ONE;
            default: res_p0 = a;
        endcase
    end

    // Next state: a decimal ADD/SUB spends exactly one cycle in ADJUST
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept && dec_start) state_nx = ADJUST;
            ADJUST:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_nx;
    end

    generate
        if (DECIMAL_EN) begin : g_dec
            localparam int ND = WIDTH / 4;
            logic [ND-1:0]    hc_p0, hc_p1;
            logic [WIDTH-1:0] bin_p1;
            logic             cin_p1, sub_p1, v_p1;
            logic             ch;

            // Per-nibble binary carries of the same add that produced sum_p0
            always_comb begin
                ch    = cin_eff;
                hc_p0 = '0;
                for (int i = 0; i < ND; i++) begin
                    hc_p0[i] = ({1'b0, a[4*i +: 4]} + {1'b0, b_eff[4*i +: 4]} + {4'd0, ch}) > 5'd15;
                    ch       = hc_p0[i];
                end
            end

            // Stage p1: hold the binary intermediate for the ADJUST cycle
            always_ff @(posedge clk) begin
                if (accept && dec_start) begin
                    bin_p1 <= sum_p0[WIDTH-1:0];
                    hc_p1  <= hc_p0;
                    cin_p1 <= carry_in;
                    sub_p1 <= (op_p0 == SUB);
                    v_p1   <= v_vec_p0[WIDTH-1];
                end
            end

            bcd_adjust #(.NDIGIT(ND)) u_bcd (
                .bin  (bin_p1),
                .hc   (hc_p1),
                .cin  (cin_p1),
                .sub  (sub_p1),
                .res  (adj_res),
                .cout (adj_c)
            );
            assign adj_v = v_p1;
        end else begin : g_bin
            assign adj_res = '0;
            assign adj_c   = 1'b0;
            assign adj_v   = 1'b0;
        end
    endgenerate

    // Output beat: created by a binary accept or by ADJUST, held until taken
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            carry_out <= 1'b0;
            overflow  <= 1'b0;
            zero      <= 1'b0;
            sign      <= 1'b0;
        end else if (accept && !dec_start) begin
            out_valid <= 1'b1;
            result    <= res_p0;
            carry_out <= c_p0;
            overflow  <= v_p0;
            zero      <= (res_p0 == '0);
            sign      <= res_p0[WIDTH-1];
        end else if (state == ADJUST) begin
            out_valid <= 1'b1;
            result    <= adj_res;
            carry_out <= adj_c;
            overflow  <= adj_v;
            zero      <= (adj_res == '0);
            sign      <= adj_res[WIDTH-1];
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Scoreboard bench for alu_seq: expected beats are queued at accept time
// from an arithmetic reference model and popped by an output monitor.
module tb_alu_seq;
    import alu_pkg::*;

    typedef struct packed {
        logic [7:0] r;
        logic       c;
        logic       v;
        logic       z;
        logic       n;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] op = 4'd0;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic       carry_in = 1'b0;
    logic       decimal = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b1;
    logic [7:0] result;
    logic       carry_out, overflow, zero, sign;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb_q[$];
    bit   mc = 1'b0;
    bit   mv = 1'b0;
    bit   rand_ready = 1'b0;
    bit   held = 1'b0;

    alu_seq #(.WIDTH(8), .DECIMAL_EN(1'b1)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .a         (a),
        .b         (b),
        .carry_in  (carry_in),
        .decimal   (decimal),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .carry_out (carry_out),
        .overflow  (overflow),
        .zero      (zero),
        .sign      (sign)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, req);
        end
    endtask

    function automatic int to_dec(input int x);
        return (x / 16) * 10 + (x % 16);
    endfunction

    function automatic int to_bcd(input int x);
        return (x / 10) * 16 + (x % 10);
    endfunction

    // Reference model: plain integer arithmetic on values, C/V held across beats
    function automatic exp_t model(input logic [3:0] o, input int x, input int y, input int ci, input bit d);
        int   r, s, sx, sy;
        bit   c, v;
        exp_t e;
        c  = mc;
        v  = mv;
        r  = x;
        sx = (x >= 128) ? x - 256 : x;
        sy = (y >= 128) ? y - 256 : y;
        case (alu_op_t'(o))
            ADD: begin
                s = sx + sy + ci;
                v = (s > 127) || (s < -128);
                if (d) begin
                    s = to_dec(x) + to_dec(y) + ci;
                    c = (s >= 100);
                    r = to_bcd(s % 100);
                end else begin
                    s = x + y + ci;
                    c = (s > 255);
                    r = s % 256;
                end
            end
            SUB: begin
                s = sx - sy - (1 - ci);
                v = (s > 127) || (s < -128);
                if (d) begin
                    s = to_dec(x) - to_dec(y) - (1 - ci);
                    c = (s >= 0);
                    if (s < 0) s += 100;
                    r = to_bcd(s);
                end else begin
                    s = x - y - (1 - ci);
                    c = (s >= 0);
                    r = (s + 256) % 256;
                end
            end
            CMP: begin
                s = x - y;
                c = (s >= 0);
                r = (s + 256) % 256;
            end
            AND: r = x & y;
            OR:  r = x | y;
            EOR: r = x ^ y;
            ASL: begin r = (x * 2) % 256;        c = (x >= 128); end
            LSR: begin r = x / 2;                c = (x % 2) == 1; end
            ROL: begin r = (x * 2) % 256 + ci;   c = (x >= 128); end
            ROR: begin r = x / 2 + 128 * ci;     c = (x % 2) == 1; end
            INC: r = (x + 1) % 256;
            DEC: r = (x + 255) % 256;
            default: r = x;
        endcase
        mc  = c;
        mv  = v;
        e.r = r[7:0];
        e.c = c;
        e.v = v;
        e.z = (r == 0);
        e.n = (r >= 128);
        return e;
    endfunction

    // Present one op, wait (bounded) for acceptance, queue its expected beat.
    // Returns #1 after the accepting edge.
    task automatic issue(input logic [3:0] o, input logic [7:0] x, input logic [7:0] y,
                         input logic ci, input logic d, output int stalls);
        stalls   = 0;
        op       = o;
        a        = x;
        b        = y;
        carry_in = ci;
        decimal  = d;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && stalls < 100) begin
            @(negedge clk);
            stalls++;
        end
        check("accept", {31'd0, in_ready}, 32'd1);
        if (in_ready) sb_q.push_back(model(o, x, y, ci, d));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Monitor: every presented beat must match the oldest expected one
    always @(negedge clk) begin
        if (reset) begin
            held = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb_q.size() == 0) begin
                    check("stale_beat", {31'd0, out_valid}, 32'd0);
                end else begin
                    check("beat", {20'd0, result, carry_out, overflow, zero, sign}, {20'd0, sb_q[0]});
                    if (out_ready) void'(sb_q.pop_front());
                end
            end else if (held) begin
                check("hold_drop", {31'd0, out_valid}, 32'd1);
            end
            held = out_valid && !out_ready;
        end
    end

    // Random consumer backpressure
    always @(posedge clk) begin
        if (rand_ready) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int st;
        int tot;
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", {24'd0, result}, 32'd0);
        check("rst_flags", {28'd0, carry_out, overflow, zero, sign}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        issue(ADD, 8'h50, 8'h50, 1'b0, 1'b0, st);
        check("add_lat", {31'd0, out_valid}, 32'd1);
        check("add_beat", {20'd0, result, carry_out, overflow, zero, sign}, {20'd0, 8'hA0, 4'b0101});

        issue(SUB, 8'h00, 8'h01, 1'b1, 1'b0, st);
        check("sub_beat", {20'd0, result, carry_out, overflow, zero, sign}, {20'd0, 8'hFF, 4'b0001});

        issue(CMP, 8'h40, 8'h40, 1'b0, 1'b0, st);
        check("cmp_beat", {20'd0, result, carry_out, overflow, zero, sign}, {20'd0, 8'h00, 4'b1010});

        issue(ADD, 8'h58, 8'h46, 1'b1, 1'b1, st);
        check("dadd_in_ready_adj", {31'd0, in_ready}, 32'd0);
        check("dadd_not_yet", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("dadd_lat", {31'd0, out_valid}, 32'd1);
        check("dadd_beat", {20'd0, result, carry_out, overflow, zero, sign}, {20'd0, 8'h05, 4'b1100});

        issue(SUB, 8'h12, 8'h21, 1'b1, 1'b1, st);
        check("dsub_not_yet", {31'd0, out_valid}, 32'd0);
        @(posedge clk);
        #1;
        check("dsub_beat", {20'd0, result, carry_out, overflow, zero, sign}, {20'd0, 8'h91, 4'b0001});

        issue(ROR, 8'h01, 8'h00, 1'b1, 1'b0, st);
        check("ror_beat", {20'd0, result, carry_out, overflow, zero, sign}, {20'd0, 8'h80, 4'b1001});

        issue(ASL, 8'h80, 8'h00, 1'b0, 1'b0, st);
        check("asl_beat", {20'd0, result, carry_out, overflow, zero, sign}, {20'd0, 8'h00, 4'b1010});

        // Reset while the decimal op sits in ADJUST
        issue(ADD, 8'h19, 8'h01, 1'b0, 1'b1, st);
        check("rst_adj_busy", {31'd0, in_ready}, 32'd0);
        reset = 1'b1;
        sb_q.delete();
        mc = 1'b0;
        mv = 1'b0;
        @(posedge clk);
        #1 reset = 1'b0;
        check("rst_adj_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_adj_result", {24'd0, result}, 32'd0);
        check("rst_adj_flags", {28'd0, carry_out, overflow, zero, sign}, 32'd0);
        check("rst_adj_in_ready", {31'd0, in_ready}, 32'd1);
        repeat (3) @(posedge clk);
        #1;
        check("rst_adj_no_beat", {31'd0, out_valid}, 32'd0);

        // Backpressure: beat held while the next op waits
        out_ready = 1'b0;
        issue(EOR, 8'hA5, 8'h0F, 1'b0, 1'b0, st);
        op = INC; a = 8'h7F; b = 8'h00; carry_in = 1'b0; decimal = 1'b0; in_valid = 1'b1;
        repeat (5) begin
            @(negedge clk);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_held", {19'd0, out_valid, result, carry_out, overflow, zero, sign},
                  {19'd0, 1'b1, 8'hAA, 4'b0001});
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        issue(INC, 8'h7F, 8'h00, 1'b0, 1'b0, st);
        check("bp_same_edge", st, 32'd0);
        check("bp_next", {19'd0, out_valid, result, carry_out, overflow, zero, sign},
              {19'd0, 1'b1, 8'h80, 4'b0001});

        // Full-throughput stream of binary ops
        tot = 0;
        for (int i = 0; i < 8; i++) begin
            issue(4'($urandom_range(0, 12)), 8'($urandom), 8'($urandom), 1'($urandom), 1'b0, st);
            tot += st;
        end
        check("stream_stalls", tot, 32'd0);

        // Random ops, decimal only with valid BCD operands, random backpressure
        rand_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [3:0] o;
            logic [7:0] x, y;
            logic       d;
            o = 4'($urandom_range(0, 15));
            d = 1'($urandom);
            if (d && (o == ADD || o == SUB)) begin
                x = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
                y = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            end else begin
                x = 8'($urandom);
                y = 8'($urandom);
            end
            issue(o, x, y, 1'($urandom), d, st);
            if ($urandom_range(0, 4) == 0) begin
                @(posedge clk);
                #1;
            end
        end
        rand_ready = 1'b0;
        @(posedge clk);
        #1 out_ready = 1'b1;
        for (int k = 0; k < 200 && sb_q.size() != 0; k++) @(posedge clk);
        check("drain_empty", sb_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Registered, parametrised successor to the combinational 6502 datapath ALU.
- Performs binary arithmetic, logic, shift and rotate operations of width WIDTH.
- Performs optional packed-BCD add/subtract, which is multi-cycle.
- Uses valid/ready handshakes on input and output, so the CPU sequencer or a DMA/test master can stall it; result and N/V/Z/C flags are delivered together in one output beat.

Parameters:
- WIDTH, 8: operand/result width; must be a multiple of 4 when DECIMAL_EN=1.
- DECIMAL_EN, 1: 1 = BCD add/sub supported; 0 = the decimal input is ignored.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- in_valid  input  1  operation presented.
- in_ready  output  1  block can accept an operation this cycle.
- op  input  4  alu_op_t operation code.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (ignored for shifts/rotates/INC/DEC/PASS).
- carry_in  input  1  carry/borrow-not in; rotate fill bit.
- decimal  input  1  BCD mode for ADD/SUB.
- out_valid  output  1  result beat held.
- out_ready  input  1  consumer takes the beat.
- result  output  WIDTH  result.
- carry_out  output  1  C flag.
- overflow  output  1  V flag.
- zero  output  1  Z flag (result == 0).
- sign  output  1  N flag (result MSB).

Behaviour:
- Reset, synchronous: state=IDLE, out_valid=0, result=0, all flags=0. in_ready=1 the cycle after reset deasserts. Reset overrides any in-flight operation, including ADJUST, and discards a held beat.
- Accept: an operation is accepted on a rising edge where in_valid && in_ready.
- in_ready = (state==IDLE) && (!out_valid || out_ready). Accept-and-drain in the same cycle is legal and gives full throughput.
- States: IDLE, ADJUST.
  - IDLE → ADJUST on accept of ADD/SUB with decimal=1 and DECIMAL_EN=1.
  - ADJUST → IDLE unconditionally after one cycle.
- Latency: binary ops give out_valid=1 on the cycle after accept. Decimal ADD/SUB gives out_valid=1 two cycles after accept.
- Holding: out_valid plus result/flags hold stable until out_ready=1. They deassert on the edge where out_ready=1 and no new result completes.
- Ops and results (W = WIDTH):
  - ADD: a+b+cin. C = bit W of the W+1 sum. V = (~(a^b) & (a^r))[W-1].
  - SUB: a+~b+cin (cin=1 means no borrow). C = no-borrow. V = ((a^b) & (a^r))[W-1].
  - CMP: same as SUB with cin forced 1. V unchanged (held from the previous beat).
  - AND, OR, EOR: bitwise. C and V unchanged.
  - ASL: r = a<<1; C = a[W-1].
  - LSR: r = a>>1; C = a[0].
  - ROL: r = {a[W-2:0], cin}; C = a[W-1].
  - ROR: r = {cin, a[W-1:1]}; C = a[0].
  - INC: a+1. DEC: a-1. C and V unchanged for both.
  - PASS: r = a; C and V unchanged.
  - Unused codes behave as PASS.
- "Unchanged" means the C/V value from the previously delivered beat, held in an internal flag register that updates only on output-beat creation.
- Z and N are always computed from the final result.
- Decimal mode:
  - Cycle 1 computes the binary per-nibble sums/differences and latches the nibble carries.
  - ADJUST applies the per-nibble ±6 correction with carry ripple across W/4 nibbles.
  - C = decimal carry out (no-borrow for SUB).
  - V is taken from the binary intermediate.
  - Z/N are taken from the adjusted result.
- Inputs containing non-BCD digits: the result is defined only as the deterministic output of the correction algorithm; it is not checked.
- With DECIMAL_EN=0 or a non-ADD/SUB op, decimal is ignored and the op has 1-cycle latency.

Decomposition:
- alu_pkg holds:
  - alu_op_t: 4-bit enum ADD, SUB, CMP, AND, OR, EOR, ASL, LSR, ROL, ROR, INC, DEC, PASS.
  - alu_state_t: IDLE, ADJUST.
  - Constant BCD_CORR = 4'd6.
- Sub-module bcd_adjust: parametrised on ndigit count. Combinational per-nibble correction plus carry ripple, instantiated once under generate when DECIMAL_EN=1.

Test Plan:
- ADD a=0x50 b=0x50 cin=0 → result 0xA0, V=1 N=1 C=0 Z=0, out_valid exactly 1 cycle after accept.
- SUB a=0x00 b=0x01 cin=1 → 0xFF, C=0 N=1 V=0. Then CMP a=0x40 b=0x40 → 0x00, Z=1 C=1, V still 0.
- Decimal ADD a=0x58 b=0x46 cin=1 → 0x05, C=1. in_ready=0 during ADJUST; out_valid 2 cycles after accept. Decimal SUB a=0x12 b=0x21 cin=1 → 0x91, C=0.
- ROR a=0x01 cin=1 → 0x80, C=1 N=1. Then ASL a=0x80 → 0x00, C=1 Z=1.
- Backpressure:
  - Hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0 and result/flags stable throughout.
  - Raise out_ready → held beat drains and the next op is accepted on the same edge.
  - Back-to-back stream of 8 binary ops at full throughput with no bubbles.
- Assert reset in the ADJUST cycle → next cycle out_valid=0, result=0, flags=0, in_ready=1. No stale beat ever appears.
